lab2_out_monitor: RTL and testbench
===================================

// Module: lab2_out_monitor
// PURPOSE
//  Synthesizable response-side counterpart to the lab2 stimulus driver: watches the 4-bit
//  lab2 output y1 and logs every value change as a timestamped event.
//  Events are queued in a small FIFO and read out over a valid/ready port.
//  Also checks y1 against an expected-value stream and counts mismatches.
//  Sits beside the lab2 datapath, between the DUT output and a host/scoreboard.
// PARAMETERS
//  WIDTH  4   width of monitored output and expected data
//  TS_W   16  timestamp counter width (cycles since arm)
//  DEPTH  4   event FIFO depth; power of two, >= 2
// PORTS
//  clk           in   1      single clock, all logic on rising edge
//  rst_n         in   1      reset, synchronous, active-low
//  start         in   1      arm monitor (accepted in IDLE or DONE only)
//  stop          in   1      end capture (accepted in RUN only)
//  dut_y         in   WIDTH  monitored DUT output (y1)
//  exp_valid     in   1      expected value present
//  exp_data      in   WIDTH  expected value of dut_y for this cycle
//  exp_ready     out  1      monitor accepts expected values (=1 only in RUN)
//  evt_valid     out  1      event at FIFO head
//  evt_ready     in   1      consumer pops head when evt_valid & evt_ready
//  evt_data      out  WIDTH  logged dut_y value
//  evt_ts        out  TS_W   timestamp of logged change
//  busy          out  1      state is ARM, RUN or DRAIN
//  done          out  1      state is DONE
//  mismatch_cnt  out  8      expected-vs-actual mismatches, saturates at 255
//  overflow      out  1      sticky: an event was dropped on full FIFO
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, ts=0, state IDLE; applies at any edge incl. mid-RUN/DRAIN.
//  FSM: IDLE -start-> ARM; ARM -(always, 1 cycle)-> RUN; RUN -stop-> DRAIN;
//   DRAIN -(FIFO empty)-> DONE; DONE -start-> ARM. start outside IDLE/DONE and stop outside RUN ignored.
//  ARM: clears ts, mismatch_cnt, overflow; samples dut_y into prev; pushes baseline event
//   {dut_y, ts=0} (FIFO guaranteed empty at ARM).
//  RUN: ts increments every cycle, wraps 2^TS_W-1 -> 0 silently. First RUN cycle has ts=1.
//   If dut_y != prev: push {dut_y, ts}, prev <= dut_y. Equal values push nothing.
//   stop and a change in the same cycle: change is logged, then DRAIN.
//  Expected check: handshake exp_valid & exp_ready; compare exp_data to same-cycle dut_y;
//   unequal -> mismatch_cnt+1 (hold at 255). exp_valid outside RUN ignored.
//  FIFO: show-ahead; push at edge k -> evt_valid=1 after edge k if previously empty.
//   Push when full and no pop same cycle: event dropped, overflow<=1 (sticky until ARM).
//   Push and pop in same cycle when full: both succeed, no overflow.
//   Pop on empty: no effect. evt_data/evt_ts hold last head value when empty (0 after reset).
//  DRAIN: no new events, ts frozen; consumer empties FIFO; DONE held until start or reset.
// STRUCTURE
//  Package lab2_mon_pkg: state enum (IDLE, ARM, RUN, DRAIN, DONE), MISMATCH_MAX=8'd255,
//   event record widths.
//  Sub-module lab2_evt_fifo (WIDTH+TS_W data, DEPTH entries, ptrs with extra wrap bit
//   for full/empty). Top holds FSM, prev reg, ts counter, compare/count logic.
// TESTING
//  1 Reset, start, dut_y held 4'b0000 -> exactly one event {0000, ts=0}; then stop -> DONE
//    once popped.
//  2 dut_y 0000->1010 at ts=2, ->1111 at ts=4, evt_ready=1 -> events {0000,0},{1010,2},
//    {1111,4} in order.
//  3 evt_ready=0, 6 changes after arm (DEPTH=4) -> 4 events kept (baseline+first 3),
//    overflow=1; re-start clears it.
//  4 exp stream 1010,0101,1100 vs dut_y 1010,0111,1100 -> mismatch_cnt=1; 300 bad
//    compares -> 255.
//  5 FIFO full, push+pop same cycle -> no overflow, count stays 4; TS_W=4 run 20 cycles
//    -> ts wraps 15->0.
//  6 rst_n=0 mid-RUN with 3 queued -> next cycle evt_valid=0, busy=0, state IDLE, counts 0.

Source files
------------

// File: rtl/lab2_mon_pkg.sv
// Shared types and constants for the lab2 output monitor: FSM states, the
// mismatch saturation value and event record sizing.
package lab2_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StDrain,
    StDone
  } mon_state_e;

  localparam logic [7:0] MISMATCH_MAX = 8'd255;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_TS_W  = 16;
  localparam int unsigned DEF_DEPTH = 4;

  // An event record is {value, timestamp}.
  function automatic int unsigned evt_bits(input int unsigned width, input int unsigned ts_w);
    return width + ts_w;
  endfunction

endpackage

// File: rtl/lab2_evt_fifo.sv
// Show-ahead event FIFO with wrap-bit pointers. The head output holds the last
// popped entry while empty, so the consumer never sees stale storage.
module lab2_evt_fifo #(
  parameter int unsigned DW    = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] last_head;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so a push into a full FIFO still fits.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? last_head : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_head <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW + 1)'(1);
      end
      if (do_pop) begin
        last_head <= mem[rd_ptr[AW-1:0]];
        rd_ptr    <= rd_ptr + (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/lab2_out_monitor.sv
// Watches the lab2 output, logs every value change with a cycle timestamp into
// an event FIFO and counts mismatches against an expected-value stream.
module lab2_out_monitor
  import lab2_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned TS_W  = DEF_TS_W,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] dut_y,
  input  logic             exp_valid,
  input  logic [WIDTH-1:0] exp_data,
  output logic             exp_ready,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic [TS_W-1:0]  evt_ts,
  output logic             busy,
  output logic             done,
  output logic [7:0]       mismatch_cnt,
  output logic             overflow
);

  localparam int unsigned EW = evt_bits(WIDTH, TS_W);

  mon_state_e       state;
  logic [WIDTH-1:0] prev;
  logic [TS_W-1:0]  ts;
  logic             push;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    head;
  logic             empty;
  logic             full;

  assign push      = (state == StArm) || ((state == StRun) && (dut_y != prev));
  // The baseline event is always stamped 0.
  assign push_data = {dut_y, (state == StArm) ? {TS_W{1'b0}} : ts};
  assign evt_valid = !empty;
  assign evt_data  = head[EW-1:TS_W];
  assign evt_ts    = head[TS_W-1:0];

  lab2_evt_fifo #(
    .DW    (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_ready),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= StIdle;
      prev         <= '0;
      ts           <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      exp_ready    <= 1'b0;
    end else begin
      if (push && full && !evt_ready) begin
        overflow <= 1'b1;
      end
      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            state        <= StArm;
            ts           <= '0;
            mismatch_cnt <= '0;
            overflow     <= 1'b0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        StArm: begin
          prev      <= dut_y;
          ts        <= TS_W'(1);
          state     <= StRun;
          exp_ready <= 1'b1;
        end
        StRun: begin
          prev <= dut_y;
          ts   <= ts + TS_W'(1);
          if (exp_valid && exp_ready && (exp_data != dut_y) && (mismatch_cnt != MISMATCH_MAX)) begin
            mismatch_cnt <= mismatch_cnt + 8'd1;
          end
          if (stop) begin
            state     <= StDrain;
            exp_ready <= 1'b0;
          end
        end
        StDrain: begin
          if (empty) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lab2_out_monitor.sv
// Randomized scoreboard bench for lab2_out_monitor: a queue-based reference model
// predicts events and status; a monitor pops and compares on each handshake.
module tb_lab2_out_monitor;

  localparam int DEPTH = 4;
  localparam int PH_IDLE = 0, PH_ARM = 1, PH_RUN = 2, PH_DRAIN = 3, PH_DONE = 4;

  typedef struct {
    logic [3:0] y;
    int         ts;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [3:0]  dut_y = '0;
  logic        exp_valid = 1'b0;
  logic [3:0]  exp_data = '0;
  logic        evt_ready = 1'b0;

  logic        exp_ready, evt_valid, busy, done, overflow;
  logic [3:0]  evt_data;
  logic [15:0] evt_ts;
  logic [7:0]  mismatch_cnt;

  logic        exp_ready4, evt_valid4, busy4, done4, overflow4;
  logic [3:0]  evt_data4;
  logic [3:0]  evt_ts4;
  logic [7:0]  mismatch_cnt4;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int         m_phase = PH_IDLE;
  int         occ = 0;
  int         m_mm = 0;
  int         m_ts = 0;
  bit         m_ovf = 1'b0;
  logic [3:0] m_prev = '0;
  ev_t        m_last = '{y: 4'd0, ts: 0};
  ev_t        sb[$];
  logic [3:0] cur_y = '0;

  lab2_out_monitor #(.WIDTH(4), .TS_W(16), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dut_y(dut_y),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .evt_ts(evt_ts),
    .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .overflow(overflow)
  );

  lab2_out_monitor #(.WIDTH(4), .TS_W(4), .DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dut_y(dut_y),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready4),
    .evt_valid(evt_valid4), .evt_ready(evt_ready), .evt_data(evt_data4), .evt_ts(evt_ts4),
    .busy(busy4), .done(done4), .mismatch_cnt(mismatch_cnt4), .overflow(overflow4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops the scoreboard on every consumer handshake.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        chk("evt_pop_with_empty_scoreboard", sb.size(), 1);
      end else begin
        ev_t e;
        e = sb.pop_front();
        chk("evt_data", evt_data, e.y);
        chk("evt_ts", evt_ts, e.ts % 65536);
        chk("evt_data_ts4", evt_data4, e.y);
        chk("evt_ts_ts4", evt_ts4, e.ts % 16);
      end
    end
  end

  task automatic m_reset();
    m_phase = PH_IDLE;
    occ     = 0;
    m_mm    = 0;
    m_ts    = 0;
    m_ovf   = 1'b0;
    m_prev  = '0;
    m_last  = '{y: 4'd0, ts: 0};
    sb.delete();
  endtask

  // One clock cycle: drive inputs, advance the model, then check after the edge.
  task automatic step(input logic st, input logic sp, input logic [3:0] y, input logic rdy,
                      input logic ev, input logic [3:0] ed);
    bit  pop;
    bit  push;
    ev_t e;
    start = st; stop = sp; dut_y = y; evt_ready = rdy; exp_valid = ev; exp_data = ed;
    cur_y = y;
    if (!rst_n) begin
      m_reset();
    end else begin
      pop  = rdy && (occ > 0);
      push = 1'b0;
      e    = '{y: y, ts: 0};
      case (m_phase)
        PH_IDLE, PH_DONE: if (st) begin
          m_phase = PH_ARM; m_mm = 0; m_ovf = 1'b0;
        end
        PH_ARM: begin
          push = 1'b1; e = '{y: y, ts: 0}; m_prev = y; m_ts = 1; m_phase = PH_RUN;
        end
        PH_RUN: begin
          if (y != m_prev) begin
            push = 1'b1; e = '{y: y, ts: m_ts}; m_prev = y;
          end
          if (ev && (ed != y) && (m_mm < 255)) m_mm++;
          m_ts++;
          if (sp) m_phase = PH_DRAIN;
        end
        PH_DRAIN: if (occ == 0) m_phase = PH_DONE;
        default: ;
      endcase
      if (pop) m_last = sb[0];
      if (push) begin
        if ((occ < DEPTH) || pop) begin
          sb.push_back(e);
          occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (pop) occ--;
    end
    @(posedge clk);
    #1;
    chk("busy", busy, (m_phase >= PH_ARM) && (m_phase <= PH_DRAIN));
    chk("done", done, m_phase == PH_DONE);
    chk("done_ts4", done4, m_phase == PH_DONE);
    chk("exp_ready", exp_ready, m_phase == PH_RUN);
    chk("mismatch_cnt", mismatch_cnt, m_mm);
    chk("overflow", overflow, m_ovf);
    chk("overflow_ts4", overflow4, m_ovf);
    chk("evt_valid", evt_valid, occ > 0);
    chk("evt_valid_ts4", evt_valid4, occ > 0);
    if (occ == 0) begin
      chk("evt_data_hold", evt_data, m_last.y);
      chk("evt_ts_hold", evt_ts, m_last.ts % 65536);
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_y, rdy, 1'b0, 4'd0);
  endtask

  task automatic arm(input logic [3:0] y, input logic rdy);
    step(1'b1, 1'b0, y, rdy, 1'b0, 4'd0);  // start accepted
    step(1'b0, 1'b0, y, rdy, 1'b0, 4'd0);  // baseline cycle
  endtask

  task automatic finish_run();
    step(1'b0, 1'b1, cur_y, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 40 && m_phase != PH_DONE; i++) step(1'b0, 1'b0, cur_y, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, cur_y, 1'b0, 1'b0, 4'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] y;
    logic [3:0] ed;
    int         len;
    logic [3:0] seq_y [3];
    logic [3:0] seq_e [3];

    // Reset state
    do_reset(2);
    chk("reset_evt_data", evt_data, 0);
    chk("reset_mismatch", mismatch_cnt, 0);
    idle(2, 1'b1);

    // 1: single baseline event, then DONE once popped
    arm(4'b0000, 1'b1);
    idle(4, 1'b1);
    finish_run();
    chk("t1_done", done, 1);

    // 2: changes at ts=2 and ts=4
    arm(4'b0000, 1'b1);
    step(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'b1010, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'd0);
    finish_run();

    // 3: six changes with consumer stalled -> overflow, cleared on re-arm
    arm(4'b0000, 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b0, 4'(i), 1'b0, 1'b0, 4'd0);
    chk("t3_overflow", overflow, 1);
    finish_run();
    arm(4'b0110, 1'b1);
    chk("t3_overflow_cleared", overflow, 0);
    finish_run();

    // 4: one mismatch in a three-value stream, then saturation
    seq_y = '{4'b1010, 4'b0111, 4'b1100};
    seq_e = '{4'b1010, 4'b0101, 4'b1100};
    arm(4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, seq_y[i], 1'b1, 1'b1, seq_e[i]);
    chk("t4_mismatch_1", mismatch_cnt, 1);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 4'b0011, 1'b1, 1'b1, 4'b1000);
    chk("t4_mismatch_sat", mismatch_cnt, 255);
    finish_run();

    // 5: full FIFO with push+pop in the same cycle, then timestamp wrap on TS_W=4
    arm(4'b0000, 1'b0);
    for (int i = 1; i <= 3; i++) step(1'b0, 1'b0, 4'(i + 8), 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'b0101, 1'b1, 1'b0, 4'd0);
    chk("t5_no_overflow", overflow, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'(i), 1'b1, 1'b0, 4'd0);
    finish_run();

    // 6: reset mid-RUN with three events queued
    arm(4'b0001, 1'b0);
    step(1'b0, 1'b0, 4'b0010, 1'b0, 1'b1, 4'b1111);
    step(1'b0, 1'b0, 4'b0100, 1'b0, 1'b1, 4'b1111);
    do_reset(1);
    chk("t6_evt_valid", evt_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_mismatch", mismatch_cnt, 0);
    idle(3, 1'b1);

    // Random runs, some ending in a mid-run reset
    for (int r = 0; r < 12; r++) begin
      y = 4'($urandom_range(15));
      arm(y, 1'($urandom_range(1)));
      len = $urandom_range(10, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(3) == 0) y = 4'($urandom_range(15));
        ed = ($urandom_range(2) == 0) ? 4'($urandom_range(15)) : y;
        step(1'($urandom_range(1)), 1'b0, y, 1'($urandom_range(1)),
             1'($urandom_range(1)), ed);
      end
      if (r % 4 == 3) do_reset(1);
      else finish_run();
      idle($urandom_range(0, 3), 1'($urandom_range(1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
